// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit FIFO slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        RELEASE
    } tx_state_t;

    localparam int unsigned DEFAULT_DEPTH   = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO storage: power-of-two ring buffer, full/empty derived from the level count.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign wr_ready = (r_level < (AW+1)'(DEPTH));
    assign w_wr     = wr_en & wr_ready;
    assign w_rd     = rd_en & (r_level != '0);
    assign rd_data  = r_mem[r_rd_ptr];
    assign level    = r_level;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit front-end: buffers bytes and hands them one at a time to the transmitter
// using a send/donetx handshake with a frame timeout.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic                     send,
    output logic [7:0]               tx_data,
    input  logic                     donetx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow,
    output logic                     tx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    tx_state_t           r_state;
    logic                r_send;
    logic [7:0]          r_tx_data;
    logic [TW-1:0]       r_timer;
    logic                r_overflow;
    logic                r_tx_err;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync_d;
    logic                w_pop;
    logic                w_done_rise;
    logic                w_wr_ready;
    logic [7:0]          w_rd_data;
    logic [$clog2(DEPTH):0] w_level;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .level   (w_level),
        .wr_ready(w_wr_ready)
    );

    assign w_pop       = (r_state == LOAD);
    assign w_done_rise = r_sync2 & ~r_sync_d;

    assign wr_ready = w_wr_ready;
    assign level    = w_level;
    assign send     = r_send;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;
    assign tx_err   = r_tx_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_send     <= 1'b0;
            r_tx_data  <= '0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
            r_tx_err   <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_d   <= 1'b0;
        end else begin
            r_sync1  <= donetx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (wr_valid && !w_wr_ready) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_level != '0) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_data <= w_rd_data;
                    r_send    <= 1'b1;
                    r_timer   <= '0;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (w_done_rise) begin
                        r_send  <= 1'b0;
                        r_state <= RELEASE;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_send   <= 1'b0;
                        r_tx_err <= 1'b1;
                        r_state  <= RELEASE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RELEASE: begin
                    // Wait for the transmitter to drop done so a held level cannot retrigger.
                    if (!r_sync2) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, TIMEOUT=100).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       send;
    logic [7:0] tx_data;
    logic       donetx;
    logic [4:0] level;
    logic       busy;
    logic       overflow;
    logic       tx_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .DEPTH  (16),
        .TIMEOUT(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .send    (send),
        .tx_data (tx_data),
        .donetx  (donetx),
        .level   (level),
        .busy    (busy),
        .overflow(overflow),
        .tx_err  (tx_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_send(input logic val, input int unsigned budget, output bit ok);
        int unsigned c = 0;
        while (send !== val && c < budget) begin
            step();
            c++;
        end
        ok = (send === val);
    endtask

    task automatic wait_idle(input int unsigned budget, output bit ok);
        int unsigned c = 0;
        while (busy !== 1'b0 && c < budget) begin
            step();
            c++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; donetx = 1'b0;
        step(); step();
        n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", send); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0 || tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b err=%b expected 0 0", overflow, tx_err); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        write_byte(8'hA5);
        n_checks++; if (level !== 5'd1 || send !== 1'b0) begin n_fail++; $display("FAIL single_edge1: got level=%0d send=%b expected 1 0", level, send); end
        step();
        n_checks++; if (busy !== 1'b1 || send !== 1'b0) begin n_fail++; $display("FAIL single_edge2: got busy=%b send=%b expected 1 0", busy, send); end
        step();
        n_checks++; if (send !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0) begin n_fail++; $display("FAIL single_edge3: got send=%b data=%h level=%0d expected 1 a5 0", send, tx_data, level); end
        donetx = 1'b1;
        step(); step();
        n_checks++; if (send !== 1'b1) begin n_fail++; $display("FAIL single_sync_delay: got send=%b expected 1", send); end
        step();
        n_checks++; if (send !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_done: got send=%b busy=%b expected 0 1", send, busy); end
        donetx = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_release_hold: got busy=%b expected 1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_fill_and_order();
        bit ok;
        bit resent;
        for (int i = 1; i <= 16; i++) write_byte(8'(i));
        n_checks++; if (level !== 5'd15 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_level15: got level=%0d ovf=%b expected 15 0", level, overflow); end
        n_checks++; if (send !== 1'b1 || tx_data !== 8'h01) begin n_fail++; $display("FAIL fill_first_byte: got send=%b data=%h expected 1 01", send, tx_data); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready15: got %b expected 1", wr_ready); end
        write_byte(8'h11);
        n_checks++; if (level !== 5'd16 || wr_ready !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_17th: got level=%0d rdy=%b ovf=%b expected 16 0 0", level, wr_ready, overflow); end
        write_byte(8'h12);
        n_checks++; if (level !== 5'd16 || overflow !== 1'b1) begin n_fail++; $display("FAIL fill_18th: got level=%0d ovf=%b expected 16 1", level, overflow); end
        donetx = 1'b1;
        wait_send(1'b0, 8, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_frame1_done: got send=%b expected 0", send); end
        donetx = 1'b0;
        wait_idle(8, ok);
        n_checks++; if (!ok || level !== 5'd16) begin n_fail++; $display("FAIL fill_idle_full: got busy=%b level=%0d expected 0 16", busy, level); end
        step();
        n_checks++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL popfull_load: got busy=%b rdy=%b expected 1 0", busy, wr_ready); end
        wr_valid = 1'b1; wr_data = 8'hEE;
        step();
        wr_valid = 1'b0;
        n_checks++; if (level !== 5'd15 || send !== 1'b1 || tx_data !== 8'h02) begin n_fail++; $display("FAIL popfull_result: got level=%0d send=%b data=%h expected 15 1 02", level, send, tx_data); end
        for (int k = 2; k <= 17; k++) begin
            wait_send(1'b1, 8, ok);
            n_checks++; if (!ok || tx_data !== 8'(k)) begin n_fail++; $display("FAIL order_byte: got send=%b data=%h expected 1 %h", send, tx_data, 8'(k)); end
            donetx = 1'b1;
            wait_send(1'b0, 8, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL order_done: got send=%b expected 0 for byte %h", send, 8'(k)); end
            donetx = 1'b0;
            wait_idle(8, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL order_idle: got busy=%b expected 0 for byte %h", busy, 8'(k)); end
        end
        n_checks++; if (level !== 5'd0 || tx_err !== 1'b0) begin n_fail++; $display("FAIL order_drained: got level=%0d err=%b expected 0 0", level, tx_err); end
        resent = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (send !== 1'b0) resent = 1'b1;
        end
        n_checks++; if (resent !== 1'b0) begin n_fail++; $display("FAIL order_no_resend: got resend=%b expected 0", resent); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit bad;
        write_byte(8'h5A);
        wait_send(1'b1, 4, ok);
        n_checks++; if (!ok || tx_data !== 8'h5A) begin n_fail++; $display("FAIL tmo_start: got send=%b data=%h expected 1 5a", send, tx_data); end
        bad = 1'b0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (send !== 1'b1 || tx_err !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got early_exit=%b expected 0", bad); end
        step();
        n_checks++; if (send !== 1'b0 || tx_err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: got send=%b err=%b busy=%b expected 0 1 1", send, tx_err, busy); end
        step();
        n_checks++; if (busy !== 1'b0 || tx_err !== 1'b1) begin n_fail++; $display("FAIL tmo_idle: got busy=%b err=%b expected 0 1", busy, tx_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit leaked;
        for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
        n_checks++; if (level !== 5'd5 || send !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got level=%0d send=%b expected 5 1", level, send); end
        rst = 1'b1;
        step();
        n_checks++; if (send !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got send=%b level=%0d busy=%b expected 0 0 0", send, level, busy); end
        n_checks++; if (overflow !== 1'b0 || tx_err !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_flags: got ovf=%b err=%b data=%h expected 0 0 00", overflow, tx_err, tx_data); end
        rst = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (send !== 1'b0 || level !== 5'd0) leaked = 1'b1;
        end
        n_checks++; if (leaked !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: got leaked=%b expected 0", leaked); end
    endtask

    task automatic test_done_held();
        bit ok;
        bit prev;
        int rises;
        bit resent;
        write_byte(8'h33);
        write_byte(8'h44);
        wait_send(1'b1, 6, ok);
        n_checks++; if (!ok || tx_data !== 8'h33) begin n_fail++; $display("FAIL held_first: got send=%b data=%h expected 1 33", send, tx_data); end
        donetx = 1'b1;
        prev = send;
        rises = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (send === 1'b1 && prev == 1'b0) rises++;
            prev = send;
        end
        n_checks++; if (rises != 0 || send !== 1'b0) begin n_fail++; $display("FAIL held_no_dup: got rises=%0d send=%b expected 0 0", rises, send); end
        n_checks++; if (level !== 5'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL held_one_pop: got level=%0d busy=%b expected 1 1", level, busy); end
        donetx = 1'b0;
        wait_send(1'b1, 10, ok);
        n_checks++; if (!ok || tx_data !== 8'h44 || level !== 5'd0) begin n_fail++; $display("FAIL held_second: got send=%b data=%h level=%0d expected 1 44 0", send, tx_data, level); end
        donetx = 1'b1;
        wait_send(1'b0, 8, ok);
        donetx = 1'b0;
        wait_idle(8, ok);
        n_checks++; if (!ok || tx_err !== 1'b0) begin n_fail++; $display("FAIL held_finish: got busy=%b err=%b expected 0 0", busy, tx_err); end
        resent = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (send !== 1'b0) resent = 1'b1;
        end
        n_checks++; if (resent !== 1'b0) begin n_fail++; $display("FAIL held_no_resend: got resend=%b expected 0", resent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_order();
        test_timeout();
        test_reset_mid_frame();
        test_done_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
